// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared state encodings and source indices for the LED arbiter
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } led_arb_state_t;

    localparam logic [1:0] SRC_ERR   = 2'd0;
    localparam logic [1:0] SRC_CYLON = 2'd1;
    localparam logic [1:0] SRC_STAT  = 2'd2;
    localparam logic [1:0] SRC_ACT   = 2'd3;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running prescaler producing a tick every 2^MXPRE clocks
module led_tick_gen #(
    parameter int MXPRE = 24
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [MXPRE-1:0] prescaler;

    // Free-running up-counter; only reset can realign the tick phase
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign tick = &prescaler;

endmodule

// File: rtl/led_source_arbiter.sv
// rtl/led_source_arbiter.sv - fixed-priority LED bank sharing with dwell, error preemption and blank gaps
module led_source_arbiter
    import led_arb_pkg::*;
#(
    parameter int MXPRE = 24,
    parameter int DWELL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] src0_q,
    input  logic [15:0] src1_q,
    input  logic [15:0] src2_q,
    input  logic [15:0] src3_q,
    input  logic        force_en,
    input  logic [1:0]  force_src,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic [15:0] q,
    output logic        switching
);

    localparam logic [3:0] DWELL_MAX = 4'(DWELL);

    led_arb_state_t state;
    led_arb_state_t state_nxt;
    logic [1:0]     sel_nxt;
    logic           take_grant;
    logic [3:0]     ereq;
    logic [1:0]     hp;
    logic [3:0]     dwell;
    logic           dwell_done;
    logic           tick;
    logic [15:0]    src_mux;

    led_tick_gen #(
        .MXPRE(MXPRE)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign ereq       = force_en ? (4'b0001 << force_src) : req;
    assign dwell_done = (dwell == DWELL_MAX);

    // Priority encoder: lowest set request index wins
    always_comb begin
        hp = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ereq[i]) begin
                hp = 2'(i);
            end
        end
    end

    // Pattern mux for the currently selected source
    always_comb begin
        case (sel)
            2'd0:    src_mux = src0_q;
            2'd1:    src_mux = src1_q;
            2'd2:    src_mux = src2_q;
            default: src_mux = src3_q;
        endcase
    end

    // Next-state logic: grant from IDLE/BLANK, exit SHOW on drop, error preemption or expired dwell
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        take_grant = 1'b0;
        case (state)
            IDLE: begin
                if (|ereq) begin
                    state_nxt  = SHOW;
                    sel_nxt    = hp;
                    take_grant = 1'b1;
                end
            end
            SHOW: begin
                if (!ereq[sel] || ((hp < sel) && ((hp == SRC_ERR) || dwell_done))) begin
                    state_nxt = BLANK;
                end
            end
            BLANK: begin
                if (tick) begin
                    if (|ereq) begin
                        state_nxt  = SHOW;
                        sel_nxt    = hp;
                        take_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dwell counter: cleared on each grant, counts ticks while shown, saturates at DWELL
    always_ff @(posedge clock) begin
        if (reset || take_grant) begin
            dwell <= 4'd0;
        end else if ((state == SHOW) && tick && !dwell_done) begin
            dwell <= dwell + 4'd1;
        end
    end

    // Registered outputs; q lags grant by one clock and is blank outside SHOW
    always_ff @(posedge clock) begin
        if (reset) begin
            grant     <= 4'd0;
            sel       <= 2'd0;
            q         <= 16'd0;
            switching <= 1'b0;
        end else begin
            grant     <= (state_nxt == SHOW) ? (4'b0001 << sel_nxt) : 4'd0;
            sel       <= sel_nxt;
            switching <= take_grant;
            q         <= (state == SHOW) ? src_mux : 16'd0;
        end
    end

endmodule

// File: doc/led_source_arbiter.md
# led_source_arbiter

Shares the front-panel 16-LED bank between four pattern generators: error indicator, cylon, status and activity. Each generator requests the display. The block grants one generator at a time by fixed priority. A grant is held for a minimum human-visible dwell time, except that the error source preempts at once. A blank gap is inserted between sources so that each transition is visible. The block sits between the pattern generators and the LED output pins.

## Interface
Parameters:
- `MXPRE`, default 24: prescaler width. One tick fires every 2^MXPRE clocks. Benches use 2.
- `DWELL`, default 4: minimum ticks a granted source is held before a lower-priority preemption. Range 1..15.

Ports:
- `clock`, in, 1: system clock, sole clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 4: display requests. Bit 0 (error) has highest priority; bit 3 has lowest.
- `src0_q`..`src3_q`, in, 16 each: pattern inputs, already registered by their generators.
- `force_en`, in, 1: manual override from a slow-control register.
- `force_src`, in, 2: source index used when `force_en`=1.
- `grant`, out, 4: one-hot grant, registered.
- `sel`, out, 2: index of the granted source, registered.
- `q`, out, 16: LED drive, registered.
- `switching`, out, 1: one-cycle pulse on every new grant.

## Operation
- Effective request `ereq = force_en ? (4'b1 << force_src) : req`. It is evaluated combinationally every clock.
- Prescaler: MXPRE-bit free-running up-counter. `tick` = (prescaler == all ones). It is never reset except by `reset`.
- Dwell counter: 4-bit. Cleared on grant. Increments on `tick` while in SHOW. Saturates at `DWELL`. `dwell_done` = (dwell == DWELL).
- `hp` = the lowest set index of `ereq`.
- State IDLE:
  - `grant`=0, `q`=0.
  - If `ereq`≠0, then on the next clock: state becomes SHOW, `sel`=hp, `grant`=onehot(hp), dwell=0, `switching`=1.
- State SHOW(sel): `q` follows `src[sel]_q`. Exit to BLANK (grant cleared) on the first clock where any of these holds:
  - `ereq[sel]`=0, i.e. the request was dropped or the force target changed.
  - `hp`<`sel` and `hp`==0. Error preemption ignores dwell.
  - `hp`<`sel` and `dwell_done`.
- Otherwise the block stays in SHOW. A lower-priority request never preempts.
- State BLANK:
  - `q`=0, `grant`=0.
  - Held until the next `tick`. On that clock: if `ereq`≠0, grant hp as in IDLE; else go to IDLE.
- Simultaneous events:
  - If `dwell_done` is reached on the same clock that a higher request asserts, the block exits.
  - If `reset` and any event coincide, `reset` wins.
- Reset mid-operation forces IDLE within one clock with all outputs at reset value. No blank gap is inserted.

## Timing
- Reset values:
  - `grant`=0, `sel`=0, `q`=0, `switching`=0.
  - state=IDLE, prescaler=0, dwell=0.
- Grant latency from IDLE: 1 clock from `ereq`≠0 to `grant`/`switching`. `q` shows the source pattern 1 clock after `grant` (registered mux).
- Exit latency from SHOW: `grant` drops 1 clock after the exit condition. `q` goes to 0 on the following clock.
- BLANK length: 1..2^MXPRE clocks, depending on prescaler phase. It is never 0.
- `switching` is exactly 1 clock wide, coincident with the first cycle of the new `grant`.
- `q` carries one extra flop of latency versus `src*_q`. `q` is never driven from a non-granted source.

## Structure
- Shared header `led_arb_pkg` holds:
  - the state encodings IDLE=2'd0, SHOW=2'd1, BLANK=2'd2;
  - the source index constants SRC_ERR=0, SRC_CYLON=1, SRC_STAT=2, SRC_ACT=3.
- One sub-module, `led_tick_gen`: the MXPRE-bit prescaler producing `tick`. It is parameterised identically so that other LED blocks can reuse it.
- Priority encoder, dwell counter, FSM and output mux live in the top module.

## Test plan
All scenarios use MXPRE=2 (tick every 4 clocks) and DWELL=2.
1. Reset mid-SHOW with `req`=4'b0010. Assert `reset` for 1 clock → next clock: `grant`=0, `q`=0, `switching`=0. After release → `grant`=4'b0010 one clock later.
2. `req` rises to 4'b1000 from IDLE, `src3_q`=16'hA5A5 → `grant`=4'b1000 and `switching`=1 at +1 clock, `q`=16'hA5A5 at +2 clocks.
3. While source 2 is shown with dwell=0, raise `req[1]` → the grant holds until 2 ticks have elapsed. The block then goes to BLANK (`q`=0 for ≥1 clock), then `grant`=4'b0010.
4. While source 3 is shown with dwell=0, raise `req[0]` → `grant` drops on the next clock regardless of dwell. After BLANK, `grant`=4'b0001.
5. With `req`=4'b0001, set `force_en`=1 and `force_src`=2 → the error grant exits, then `grant`=4'b0100. Clearing `force_en` → the block returns to source 0 via BLANK.
6. Drop `req` entirely while in SHOW → BLANK, then IDLE on the next tick with `q`=0. Confirm `switching` pulsed exactly once per grant over the run.
